serial_rx8: RTL

SERIAL_RX8 -- requirements
Module: serial_rx8

---
 rtl/serial_rx8_pkg.sv | 30 +++
 rtl/serial_rx8_if.sv | 53 +++++
 rtl/rx_shift8.sv | 56 +++++
 rtl/serial_rx8.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/serial_rx8_pkg.sv
// ---------------------------------------------------------------------------
// serial_rx8_pkg
// Shared constants and types for the serial_rx8 byte receiver.
//   BYTE_W    : width of an assembled byte
//   BITCNT_W  : width of the in-byte bit counter (counts 0..7)
//   state_t   : receiver FSM encoding (IDLE / RECV)
//   byte_t    : one assembled byte
//   bitcnt_t  : bit counter type
// No ports (package).
// ---------------------------------------------------------------------------
package serial_rx8_pkg;

  localparam int BYTE_W   = 8;
  localparam int BITCNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  typedef logic [BYTE_W-1:0]   byte_t;
  typedef logic [BITCNT_W-1:0] bitcnt_t;

  // Counter value present on the edge that captures the 8th bit.
  localparam bitcnt_t LAST_BIT = bitcnt_t'(BYTE_W - 1);

  // Counter value after the first bit of a byte has been taken.
  localparam bitcnt_t FIRST_DONE = bitcnt_t'(1);

endpackage

// File: rtl/serial_rx8_if.sv
// ---------------------------------------------------------------------------
// serial_rx8_if
// Groups the serial input strobe, the parallel output handshake and the
// status/error flags of serial_rx8.
//   S_IN, S_EN, S_START : serial bit, bit strobe, start-of-byte qualifier
//   P_OUT, VALID, READY : holding register and valid/ready handshake
//   BUSY                : byte partially received
//   OVR, FERR, CLR_ERR  : sticky overrun / framing flags and their clear
// Modports:
//   master : the side that produces bits and consumes bytes
//   slave  : the receiver itself
// ---------------------------------------------------------------------------
interface serial_rx8_if;
  import serial_rx8_pkg::*;

  logic  S_IN;
  logic  S_EN;
  logic  S_START;
  byte_t P_OUT;
  logic  VALID;
  logic  READY;
  logic  BUSY;
  logic  OVR;
  logic  FERR;
  logic  CLR_ERR;

  modport master (
    output S_IN,
    output S_EN,
    output S_START,
    output READY,
    output CLR_ERR,
    input  P_OUT,
    input  VALID,
    input  BUSY,
    input  OVR,
    input  FERR
  );

  modport slave (
    input  S_IN,
    input  S_EN,
    input  S_START,
    input  READY,
    input  CLR_ERR,
    output P_OUT,
    output VALID,
    output BUSY,
    output OVR,
    output FERR
  );

endinterface

// File: rtl/rx_shift8.sv
// ---------------------------------------------------------------------------
// rx_shift8
// Serial-in / parallel-out shift register for the byte receiver.
// Parameter:
//   MSB_FIRST : 0 = new bits enter at the MSB and move toward the LSB, so the
//               first bit of a byte ends in bit 0; 1 = new bits enter at the
//               LSB and move toward the MSB, so the first bit ends in bit 7.
// Ports:
//   clk    : clock
//   clr    : synchronous clear to 0x00 (highest priority)
//   en     : shift one bit in on this edge
//   first  : this bit starts a new byte; older contents are discarded
//   din    : serial bit
//   q      : registered shift contents
//   q_next : value q takes if en is high this edge (lets the owner capture a
//            completed byte on the same edge as its last bit)
// ---------------------------------------------------------------------------
module rx_shift8
  import serial_rx8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic  clk,
  input  logic  clr,
  input  logic  en,
  input  logic  first,
  input  logic  din,
  output byte_t q,
  output byte_t q_next
);

  byte_t base;

  // Starting a byte shifts into an all-zero register so that bits left over
  // from an abandoned byte can never leak into the next one.
  always_comb begin
    base = first ? '0 : q;
  end

  generate
    if (MSB_FIRST == 1'b0) begin : g_lsb_first
      assign q_next = {din, base[BYTE_W-1:1]};
    end else begin : g_msb_first
      assign q_next = {base[BYTE_W-2:0], din};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/serial_rx8.sv
// ---------------------------------------------------------------------------
// serial_rx8
// Strobed serial-to-parallel byte receiver with a one-byte holding register,
// valid/ready output handshake and sticky overrun / framing-error flags.
// Parameter:
//   MSB_FIRST : 0 = first received bit lands in P_OUT[0], 1 = in P_OUT[7]
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : serial_rx8_if.slave
//         S_IN/S_EN/S_START  bit input, strobe, start-of-byte qualifier
//         P_OUT/VALID/READY  last completed byte and its handshake
//         BUSY               high while a byte is partially received
//         OVR/FERR           sticky overrun / framing flags
//         CLR_ERR            clears OVR and FERR (a same-edge event wins)
// ---------------------------------------------------------------------------
module serial_rx8
  import serial_rx8_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic         clk,
  input logic         rst,
  serial_rx8_if.slave bus
);

  state_t  state_reg;
  state_t  state_next;
  bitcnt_t cnt_reg;
  bitcnt_t cnt_next;
  byte_t   p_out_reg;
  logic    valid_reg;
  logic    ovr_reg;
  logic    ferr_reg;
  logic    busy;

  // Event decode for the current edge.
  logic  in_recv;
  logic  start_bit;
  logic  shift_en;
  logic  restart;
  logic  byte_done;
  logic  accept;
  logic  overrun;
  logic  load;
  byte_t shift_q;
  byte_t shift_next;

  always_comb begin
    in_recv   = (state_reg == RECV);
    start_bit = bus.S_EN & bus.S_START;
    // In IDLE only a qualified start bit is consumed; in RECV every strobe is.
    shift_en  = bus.S_EN & (in_recv | bus.S_START);
    restart   = start_bit & in_recv;
    byte_done = bus.S_EN & ~bus.S_START & in_recv & (cnt_reg == LAST_BIT);
    accept    = valid_reg & bus.READY;
    // A byte finishing while the previous one is still held and not being
    // taken this edge is dropped; if it is being taken, the new byte replaces
    // it without a gap in VALID.
    overrun   = byte_done & valid_reg & ~bus.READY;
    load      = byte_done & ~overrun;
  end

  rx_shift8 #(
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk    (clk),
    .clr    (rst),
    .en     (shift_en),
    .first  (bus.S_START),
    .din    (bus.S_IN),
    .q      (shift_q),
    .q_next (shift_next)
  );

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state and bit counter
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_bit) begin
          state_next = RECV;
          cnt_next   = FIRST_DONE;
        end
      end
      RECV: begin
        if (bus.S_EN) begin
          if (bus.S_START) begin
            // Early start: the partial byte is abandoned, this bit is bit 0.
            cnt_next = FIRST_DONE;
          end else if (cnt_reg == LAST_BIT) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy = (state_reg == RECV);
  end

  // ---------------------------------------------------------------------
  // Holding register, handshake and sticky flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      p_out_reg <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      p_out_reg <= shift_next;
      valid_reg <= 1'b1;
    end else if (accept) begin
      valid_reg <= 1'b0;
    end
  end

  // Set has priority over CLR_ERR so an event on the clearing edge is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_reg  <= 1'b0;
      ferr_reg <= 1'b0;
    end else begin
      if (overrun) begin
        ovr_reg <= 1'b1;
      end else if (bus.CLR_ERR) begin
        ovr_reg <= 1'b0;
      end
      if (restart) begin
        ferr_reg <= 1'b1;
      end else if (bus.CLR_ERR) begin
        ferr_reg <= 1'b0;
      end
    end
  end

  // The shift contents are only observed through shift_next on completion.
  logic unused_shift;
  assign unused_shift = ^shift_q;

  assign bus.P_OUT = p_out_reg;
  assign bus.VALID = valid_reg;
  assign bus.BUSY  = busy;
  assign bus.OVR   = ovr_reg;
  assign bus.FERR  = ferr_reg;

endmodule
